// File: rtl/fref_retimer_mc.sv
// fref_retimer_mc
// Retimes the asynchronous reference FREF into the CKV (DCO) domain, emits a
// one-cycle pulse per retimed rising edge, timestamps each edge with a
// free-running CKV counter and measures the FREF period in CKV cycles.
// A cycles-since-edge counter flags a missing reference.
//
// Ports:
//   CKV         DCO clock, the only clock of the block
//   RST         asynchronous active-high reset
//   FREF        reference input, asynchronous to CKV
//   EN          block enable, CKV domain
//   EDGESEL     0: nominal latency, 1: one extra retiming stage (quasi-static)
//   CKR         retimed FREF level
//   CKR_PULSE   one-CKV-cycle pulse on a retimed FREF rising edge
//   CKV_CNT     free-running CKV cycle counter (advances while EN=1)
//   CKV_SNAP    CKV_CNT captured at the last CKR_PULSE
//   PERIOD      CKV cycles between the last two retimed edges
//   SNAP_VLD    CKV_SNAP updated this cycle
//   PERIOD_VLD  PERIOD updated this cycle
//   TIMEOUT     sticky missing-reference flag
module fref_retimer_mc #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 4095
) (
  input  logic             CKV,
  input  logic             RST,
  input  logic             FREF,
  input  logic             EN,
  input  logic             EDGESEL,
  output logic             CKR,
  output logic             CKR_PULSE,
  output logic [CNT_W-1:0] CKV_CNT,
  output logic [CNT_W-1:0] CKV_SNAP,
  output logic [CNT_W-1:0] PERIOD,
  output logic             SNAP_VLD,
  output logic             PERIOD_VLD,
  output logic             TIMEOUT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TO_PRE  = CNT_W'(TIMEOUT_CYC - 1);

  // The CKR flop is itself the last synchroniser stage, so only
  // SYNC_STAGES-1 flops precede it; ext_q is the optional extra stage.
  logic [SYNC_STAGES-2:0] sync_q;
  logic                   ext_q;
  logic                   ckr_q, ckr_d;
  logic                   pulse_q, pulse_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       snap_q, snap_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       since_q, since_d;
  logic                   snap_vld_q, snap_vld_d;
  logic                   period_vld_q, period_vld_d;
  logic                   timeout_q, timeout_d;

  // Synchroniser runs regardless of EN so CKR always reflects FREF.
  always_ff @(posedge CKV or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      ext_q  <= 1'b0;
    end else begin
      sync_q[0] <= FREF;
      for (int unsigned i = 1; i < SYNC_STAGES - 1; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      ext_q <= sync_q[SYNC_STAGES-2];
    end
  end

  always_comb begin
    ckr_d        = EDGESEL ? ext_q : sync_q[SYNC_STAGES-2];
    // Registered rise detect: the pulse lands in the first high cycle of CKR.
    pulse_d      = EN && (state_q != IDLE) && ckr_d && !ckr_q;
    state_d      = state_q;
    cnt_d        = EN ? cnt_q + CNT_ONE : cnt_q;
    snap_d       = snap_q;
    period_d     = period_q;
    since_d      = since_q;
    snap_vld_d   = 1'b0;
    period_vld_d = 1'b0;
    timeout_d    = timeout_q;

    if (!EN) begin
      state_d   = IDLE;
      since_d   = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ACQ;
          since_d = '0;
        end
        ACQ, TRACK: begin
          // Edge capture takes priority over a timeout reached in the same cycle.
          if (pulse_d) begin
            snap_d     = cnt_q;
            snap_vld_d = 1'b1;
            since_d    = '0;
            timeout_d  = 1'b0;
            state_d    = TRACK;
            if (state_q == TRACK) begin
              period_d     = cnt_q - snap_q;
              period_vld_d = 1'b1;
            end
          end else if (since_q != TO_LIM) begin
            since_d = since_q + CNT_ONE;
            if (since_q == TO_PRE) begin
              timeout_d = 1'b1;
              state_d   = ACQ;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CKV or posedge RST) begin
    if (RST) begin
      ckr_q        <= 1'b0;
      pulse_q      <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      snap_q       <= '0;
      period_q     <= '0;
      since_q      <= '0;
      snap_vld_q   <= 1'b0;
      period_vld_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      ckr_q        <= ckr_d;
      pulse_q      <= pulse_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      period_q     <= period_d;
      since_q      <= since_d;
      snap_vld_q   <= snap_vld_d;
      period_vld_q <= period_vld_d;
      timeout_q    <= timeout_d;
    end
  end

  assign CKR        = ckr_q;
  assign CKR_PULSE  = pulse_q;
  assign CKV_CNT    = cnt_q;
  assign CKV_SNAP   = snap_q;
  assign PERIOD     = period_q;
  assign SNAP_VLD   = snap_vld_q;
  assign PERIOD_VLD = period_vld_q;
  assign TIMEOUT    = timeout_q;

endmodule

// File: tb/tb_fref_retimer_mc.sv
// tb_fref_retimer_mc
// Directed bench for fref_retimer_mc (SYNC_STAGES=2, CNT_W=8, TIMEOUT_CYC=50).
// FREF is driven 1 time unit after a CKV rising edge; iteration n of each
// scenario loop drives FREF, advances past edge n+1 and checks the outputs.
module tb_fref_retimer_mc;

  localparam int W = 8;

  logic         CKV = 1'b0;
  logic         RST;
  logic         FREF;
  logic         EN;
  logic         EDGESEL;
  logic         CKR;
  logic         CKR_PULSE;
  logic [W-1:0] CKV_CNT;
  logic [W-1:0] CKV_SNAP;
  logic [W-1:0] PERIOD;
  logic         SNAP_VLD;
  logic         PERIOD_VLD;
  logic         TIMEOUT;

  int n_tests = 0;
  int n_fail  = 0;

  fref_retimer_mc #(
    .SYNC_STAGES(2),
    .CNT_W      (W),
    .TIMEOUT_CYC(50)
  ) dut (
    .CKV       (CKV),
    .RST       (RST),
    .FREF      (FREF),
    .EN        (EN),
    .EDGESEL   (EDGESEL),
    .CKR       (CKR),
    .CKR_PULSE (CKR_PULSE),
    .CKV_CNT   (CKV_CNT),
    .CKV_SNAP  (CKV_SNAP),
    .PERIOD    (PERIOD),
    .SNAP_VLD  (SNAP_VLD),
    .PERIOD_VLD(PERIOD_VLD),
    .TIMEOUT   (TIMEOUT)
  );

  always #5 CKV = ~CKV;

  function automatic logic fr10(input int m);
    return (m >= 0) && ((m % 10) >= 5);
  endfunction

  task automatic step();
    @(posedge CKV);
    #1;
  endtask

  task automatic do_reset();
    EN   = 1'b0;
    FREF = 1'b0;
    RST  = 1'b1;
    step();
    step();
    RST  = 1'b0;
  endtask

  task automatic test_reset();
    logic [5*1+3*W-1:0] outs;
    RST = 1'b0; EN = 1'b0; FREF = 1'b0; EDGESEL = 1'b0;
    #1 RST = 1'b1;
    #2;
    outs = {CKR, CKR_PULSE, SNAP_VLD, PERIOD_VLD, TIMEOUT, CKV_CNT, CKV_SNAP, PERIOD};
    n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL reset_async got %h exp 0", outs); end
    step();
    step();
    RST = 1'b0;
    for (int n = 0; n < 6; n++) begin
      FREF = ((n % 2) == 1);
      step();
      n_tests++; if (CKV_CNT !== '0) begin n_fail++; $display("FAIL reset_en0_cnt n=%0d got %0d exp 0", n, CKV_CNT); end
      n_tests++; if ({CKR_PULSE, SNAP_VLD, PERIOD_VLD} !== 3'b000) begin n_fail++; $display("FAIL reset_en0_strobe n=%0d got %b exp 000", n, {CKR_PULSE, SNAP_VLD, PERIOD_VLD}); end
    end
  endtask

  task automatic test_lock(input logic esel);
    int   e, np;
    logic exp_ckr, exp_pulse, exp_pvld;
    e = esel ? 1 : 0;
    np = 0;
    EDGESEL = esel;
    do_reset();
    EN = 1'b1;
    for (int n = 0; n < 40; n++) begin
      FREF = ((n % 10) >= 5);
      step();
      exp_ckr   = fr10(n - 1 - e);
      exp_pulse = (n >= 6 + e) && (((n - 6 - e) % 10) == 0);
      exp_pvld  = exp_pulse && (np > 0);
      n_tests++; if (CKR !== exp_ckr) begin n_fail++; $display("FAIL lock_ckr esel=%0d n=%0d got %b exp %b", e, n, CKR, exp_ckr); end
      n_tests++; if (CKR_PULSE !== exp_pulse) begin n_fail++; $display("FAIL lock_pulse esel=%0d n=%0d got %b exp %b", e, n, CKR_PULSE, exp_pulse); end
      n_tests++; if (SNAP_VLD !== exp_pulse) begin n_fail++; $display("FAIL lock_snap_vld esel=%0d n=%0d got %b exp %b", e, n, SNAP_VLD, exp_pulse); end
      n_tests++; if (PERIOD_VLD !== exp_pvld) begin n_fail++; $display("FAIL lock_period_vld esel=%0d n=%0d got %b exp %b", e, n, PERIOD_VLD, exp_pvld); end
      n_tests++; if (CKV_CNT !== W'(n + 1)) begin n_fail++; $display("FAIL lock_cnt esel=%0d n=%0d got %0d exp %0d", e, n, CKV_CNT, n + 1); end
      if (exp_pulse) begin
        n_tests++; if (CKV_SNAP !== W'(n)) begin n_fail++; $display("FAIL lock_snap esel=%0d n=%0d got %0d exp %0d", e, n, CKV_SNAP, n); end
        n_tests++; if (PERIOD !== W'((np > 0) ? 10 : 0)) begin n_fail++; $display("FAIL lock_period esel=%0d n=%0d got %0d exp %0d", e, n, PERIOD, (np > 0) ? 10 : 0); end
        np++;
      end
    end
  endtask

  task automatic test_wrap();
    logic exp_pulse;
    EDGESEL = 1'b0;
    do_reset();
    EN = 1'b1;
    for (int n = 0; n < 291; n++) begin
      FREF = ((n % 37) >= 17);
      step();
      exp_pulse = (n >= 18) && (((n - 18) % 37) == 0);
      n_tests++; if (CKR_PULSE !== exp_pulse) begin n_fail++; $display("FAIL wrap_pulse n=%0d got %b exp %b", n, CKR_PULSE, exp_pulse); end
      n_tests++; if (CKV_CNT !== W'(n + 1)) begin n_fail++; $display("FAIL wrap_cnt n=%0d got %0d exp %0d", n, CKV_CNT, (n + 1) % 256); end
      n_tests++; if (TIMEOUT !== 1'b0) begin n_fail++; $display("FAIL wrap_timeout n=%0d got %b exp 0", n, TIMEOUT); end
      if (exp_pulse) begin
        n_tests++; if (CKV_SNAP !== W'(n)) begin n_fail++; $display("FAIL wrap_snap n=%0d got %0d exp %0d", n, CKV_SNAP, n % 256); end
        n_tests++; if (PERIOD_VLD !== (n > 18)) begin n_fail++; $display("FAIL wrap_period_vld n=%0d got %b exp %b", n, PERIOD_VLD, (n > 18)); end
        if (n > 18) begin
          n_tests++; if (PERIOD !== 8'd37) begin n_fail++; $display("FAIL wrap_period n=%0d got %0d exp 37", n, PERIOD); end
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic exp_pulse, exp_pvld, exp_to;
    EDGESEL = 1'b0;
    do_reset();
    EN = 1'b1;
    for (int n = 0; n < 126; n++) begin
      if (n < 30)       FREF = ((n % 10) >= 5);
      else if (n < 100) FREF = 1'b0;
      else              FREF = (((n - 100) % 12) >= 6);
      step();
      exp_pulse = (n == 6) || (n == 16) || (n == 26) || (n == 107) || (n == 119);
      exp_pvld  = (n == 16) || (n == 26) || (n == 119);
      exp_to    = (n >= 76) && (n < 107);
      n_tests++; if (TIMEOUT !== exp_to) begin n_fail++; $display("FAIL to_flag n=%0d got %b exp %b", n, TIMEOUT, exp_to); end
      n_tests++; if (CKR_PULSE !== exp_pulse) begin n_fail++; $display("FAIL to_pulse n=%0d got %b exp %b", n, CKR_PULSE, exp_pulse); end
      n_tests++; if (PERIOD_VLD !== exp_pvld) begin n_fail++; $display("FAIL to_period_vld n=%0d got %b exp %b", n, PERIOD_VLD, exp_pvld); end
      if (n == 107) begin
        n_tests++; if (SNAP_VLD !== 1'b1) begin n_fail++; $display("FAIL to_resnap_vld got %b exp 1", SNAP_VLD); end
        n_tests++; if (CKV_SNAP !== 8'd107) begin n_fail++; $display("FAIL to_resnap got %0d exp 107", CKV_SNAP); end
      end
      if (n == 119) begin
        n_tests++; if (PERIOD !== 8'd12) begin n_fail++; $display("FAIL to_period got %0d exp 12", PERIOD); end
      end
    end
  endtask

  task automatic test_collision();
    logic exp_pulse, exp_pvld;
    EDGESEL = 1'b0;
    do_reset();
    EN = 1'b1;
    for (int n = 0; n < 131; n++) begin
      FREF = ((n % 50) >= 25);
      step();
      exp_pulse = (n == 26) || (n == 76) || (n == 126);
      exp_pvld  = (n == 76) || (n == 126);
      n_tests++; if (TIMEOUT !== 1'b0) begin n_fail++; $display("FAIL coll_timeout n=%0d got %b exp 0", n, TIMEOUT); end
      n_tests++; if (CKR_PULSE !== exp_pulse) begin n_fail++; $display("FAIL coll_pulse n=%0d got %b exp %b", n, CKR_PULSE, exp_pulse); end
      n_tests++; if (PERIOD_VLD !== exp_pvld) begin n_fail++; $display("FAIL coll_period_vld n=%0d got %b exp %b", n, PERIOD_VLD, exp_pvld); end
      if (exp_pvld) begin
        n_tests++; if (PERIOD !== 8'd50) begin n_fail++; $display("FAIL coll_period n=%0d got %0d exp 50", n, PERIOD); end
      end
    end
  endtask

  task automatic test_enable();
    logic         exp_pulse, exp_pvld;
    logic [W-1:0] exp_cnt;
    EDGESEL = 1'b0;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      FREF = ((n % 10) >= 5);
      EN   = !((n >= 26) && (n < 45));
      step();
      exp_pulse = (n == 6) || (n == 16) || (n == 46) || (n == 56);
      exp_pvld  = (n == 16) || (n == 56);
      if (n < 26)      exp_cnt = W'(n + 1);
      else if (n < 45) exp_cnt = 8'd26;
      else             exp_cnt = W'(n - 18);
      n_tests++; if (CKR_PULSE !== exp_pulse) begin n_fail++; $display("FAIL en_pulse n=%0d got %b exp %b", n, CKR_PULSE, exp_pulse); end
      n_tests++; if (SNAP_VLD !== exp_pulse) begin n_fail++; $display("FAIL en_snap_vld n=%0d got %b exp %b", n, SNAP_VLD, exp_pulse); end
      n_tests++; if (PERIOD_VLD !== exp_pvld) begin n_fail++; $display("FAIL en_period_vld n=%0d got %b exp %b", n, PERIOD_VLD, exp_pvld); end
      n_tests++; if (CKV_CNT !== exp_cnt) begin n_fail++; $display("FAIL en_cnt n=%0d got %0d exp %0d", n, CKV_CNT, exp_cnt); end
      if (n == 46) begin
        n_tests++; if (CKV_SNAP !== 8'd27) begin n_fail++; $display("FAIL en_resnap got %0d exp 27", CKV_SNAP); end
      end
      if (n == 56) begin
        n_tests++; if (PERIOD !== 8'd10) begin n_fail++; $display("FAIL en_period got %0d exp 10", PERIOD); end
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [5*1+3*W-1:0] outs;
    EDGESEL = 1'b0;
    do_reset();
    EN = 1'b1;
    for (int n = 0; n < 17; n++) begin
      FREF = ((n % 10) >= 5);
      step();
    end
    n_tests++; if (CKR_PULSE !== 1'b1) begin n_fail++; $display("FAIL mid_pre_pulse got %b exp 1", CKR_PULSE); end
    n_tests++; if (CKV_CNT !== 8'd17) begin n_fail++; $display("FAIL mid_pre_cnt got %0d exp 17", CKV_CNT); end
    #2 RST = 1'b1;
    #1;
    outs = {CKR, CKR_PULSE, SNAP_VLD, PERIOD_VLD, TIMEOUT, CKV_CNT, CKV_SNAP, PERIOD};
    n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL mid_async_clear got %h exp 0", outs); end
    @(posedge CKV);
    #1;
    RST  = 1'b0;
    FREF = 1'b0;
    for (int n = 0; n < 17; n++) begin
      FREF = ((n % 10) >= 5);
      step();
      if (n == 6) begin
        n_tests++; if ({SNAP_VLD, PERIOD_VLD} !== 2'b10) begin n_fail++; $display("FAIL mid_acq_strobes got %b exp 10", {SNAP_VLD, PERIOD_VLD}); end
        n_tests++; if (CKV_SNAP !== 8'd6) begin n_fail++; $display("FAIL mid_acq_snap got %0d exp 6", CKV_SNAP); end
        n_tests++; if (PERIOD !== 8'd0) begin n_fail++; $display("FAIL mid_acq_period got %0d exp 0", PERIOD); end
      end
      if (n == 16) begin
        n_tests++; if (PERIOD_VLD !== 1'b1) begin n_fail++; $display("FAIL mid_track_vld got %b exp 1", PERIOD_VLD); end
        n_tests++; if (PERIOD !== 8'd10) begin n_fail++; $display("FAIL mid_track_period got %0d exp 10", PERIOD); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock(1'b0);
    test_lock(1'b1);
    test_wrap();
    test_timeout();
    test_collision();
    test_enable();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
